// File: rtl/sha256_round_ctrl.sv
// Round sequencer for the SHA-256 compression datapath: loads A..H from the hash state,
// runs the round updates paced by the message scheduler, then strobes hash accumulation.
module sha256_round_ctrl #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       w_valid,
  output logic       w_ready,
  output logic       mem_en,
  output logic [3:0] mem_addr,
  output logic [2:0] hv_idx,
  output logic [5:0] round,
  output logic       hash_we,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, INIT, ROUNDS, FINAL, DONE} state_t;

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [5:0] rnd, rnd_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      rnd   <= 6'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rnd   <= rnd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rnd_nxt   = rnd;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = INIT;
          cnt_nxt   = 3'd0;
        end
      end
      INIT: begin
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd7) begin
          state_nxt = ROUNDS;
          rnd_nxt   = 6'd0;
        end
      end
      ROUNDS: begin
        // The last round holds its index rather than wrapping, so round stays valid through FINAL.
        if (w_valid) begin
          if (rnd == LAST_ROUND) state_nxt = FINAL;
          else                   rnd_nxt   = rnd + 6'd1;
        end
      end
      FINAL: state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
        rnd_nxt   = 6'd0;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort overrides every transition, including a start seen in IDLE.
    if (abort) begin
      state_nxt = IDLE;
      cnt_nxt   = 3'd0;
      rnd_nxt   = 6'd0;
    end
  end

  always_comb begin
    w_ready  = 1'b0;
    mem_en   = 1'b0;
    mem_addr = 4'd0;
    hv_idx   = 3'd0;
    hash_we  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      INIT: begin
        busy     = 1'b1;
        mem_en   = 1'b1;
        mem_addr = {1'b0, cnt} + 4'd1;
        hv_idx   = cnt;
      end
      ROUNDS: begin
        busy    = 1'b1;
        mem_en  = w_valid;
        w_ready = w_valid;
      end
      FINAL: begin
        busy    = 1'b1;
        hash_we = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign round = rnd;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: per-cycle output vectors against hand-derived timelines
// for a 64-round instance plus a 4-round instance sharing the same stimulus.
module tb_sha256_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, w_valid;
  logic       w_ready, mem_en, hash_we, busy, done;
  logic [3:0] mem_addr;
  logic [2:0] hv_idx;
  logic [5:0] round;
  logic       w_ready4, mem_en4, hash_we4, busy4, done4;
  logic [3:0] mem_addr4;
  logic [2:0] hv_idx4;
  logic [5:0] round4;

  int total = 0;
  int bad   = 0;

  sha256_round_ctrl #(.NUM_ROUNDS(64)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .w_valid(w_valid),
    .w_ready(w_ready), .mem_en(mem_en), .mem_addr(mem_addr), .hv_idx(hv_idx),
    .round(round), .hash_we(hash_we), .busy(busy), .done(done)
  );

  sha256_round_ctrl #(.NUM_ROUNDS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .w_valid(w_valid),
    .w_ready(w_ready4), .mem_en(mem_en4), .mem_addr(mem_addr4), .hv_idx(hv_idx4),
    .round(round4), .hash_we(hash_we4), .busy(busy4), .done(done4)
  );

  always #5 clk = ~clk;

  // Output vector layout: {busy, done, hash_we, w_ready, mem_en, mem_addr, hv_idx, round}
  logic [17:0] act, act4;
  assign act  = {busy, done, hash_we, w_ready, mem_en, mem_addr, hv_idx, round};
  assign act4 = {busy4, done4, hash_we4, w_ready4, mem_en4, mem_addr4, hv_idx4, round4};

  // Expected outputs in cycle c after start was sampled at edge 0, with w_valid held high.
  function automatic logic [17:0] exp_vec(input int c, input int nr);
    logic b, d, h, wr, me;
    logic [3:0] a;
    logic [2:0] hv;
    logic [5:0] r;
    {b, d, h, wr, me, a, hv, r} = '0;
    if (c >= 1 && c <= 8) begin
      b = 1'b1; me = 1'b1; a = 4'(c); hv = 3'(c - 1);
    end else if (c >= 9 && c <= 8 + nr) begin
      b = 1'b1; wr = 1'b1; me = 1'b1; r = 6'(c - 9);
    end else if (c == 9 + nr) begin
      b = 1'b1; h = 1'b1; r = 6'(nr - 1);
    end else if (c == 10 + nr) begin
      d = 1'b1; r = 6'(nr - 1);
    end
    return {b, d, h, wr, me, a, hv, r};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b0; w_valid = 1'b1;
    #2;
    total++;
    if (act !== 18'd0) begin
      bad++; $display("[TB] FAIL reset_outputs got=%h exp=%h", act, 18'd0);
    end
    next_cycle();
    next_cycle();
    total++;
    if (act !== 18'd0 || act4 !== 18'd0) begin
      bad++; $display("[TB] FAIL reset_held got=%h/%h exp=0", act, act4);
    end
    start = 1'b0;
    rst = 1'b0;
    next_cycle();
    #1;
    total++;
    if (act !== 18'd0) begin
      bad++; $display("[TB] FAIL reset_release_idle got=%h exp=0", act);
    end
  endtask

  task automatic test_nominal();
    start = 1'b1; w_valid = 1'b1;
    for (int a = 1; a <= 76; a++) begin
      next_cycle();
      start = 1'b0;
      #1;
      total++;
      if (act !== exp_vec(a, 64)) begin
        bad++; $display("[TB] FAIL nominal c=%0d got=%h exp=%h", a, act, exp_vec(a, 64));
      end
    end
  endtask

  task automatic test_stall();
    logic [17:0] e;
    start = 1'b1; w_valid = 1'b1;
    for (int a = 1; a <= 81; a++) begin
      next_cycle();
      start = 1'b0;
      w_valid = !(a >= 19 && a <= 23);
      #1;
      if (a >= 19 && a <= 23) e = {1'b1, 4'b0000, 4'd0, 3'd0, 6'd10};
      else                    e = exp_vec(a >= 24 ? a - 5 : a, 64);
      total++;
      if (act !== e) begin
        bad++; $display("[TB] FAIL stall c=%0d got=%h exp=%h", a, act, e);
      end
    end
    w_valid = 1'b1;
  endtask

  task automatic test_abort();
    logic [17:0] e;
    start = 1'b1; w_valid = 1'b1;
    for (int a = 1; a <= 80; a++) begin
      next_cycle();
      start = 1'b0;
      abort = (a == 39);
      #1;
      e = (a <= 39) ? exp_vec(a, 64) : 18'd0;
      total++;
      if (act !== e) begin
        bad++; $display("[TB] FAIL abort_rounds c=%0d got=%h exp=%h", a, act, e);
      end
    end
    abort = 1'b0;
    // start and abort together in IDLE: abort wins
    next_cycle();
    start = 1'b1; abort = 1'b1;
    next_cycle();
    start = 1'b0; abort = 1'b0;
    #1;
    total++;
    if (act !== 18'd0) begin
      bad++; $display("[TB] FAIL abort_vs_start got=%h exp=0", act);
    end
    // abort in FINAL: that cycle's hash_we stands, done is suppressed
    start = 1'b1;
    for (int a = 1; a <= 78; a++) begin
      next_cycle();
      start = 1'b0;
      abort = (a == 73);
      #1;
      e = (a <= 73) ? exp_vec(a, 64) : 18'd0;
      total++;
      if (act !== e) begin
        bad++; $display("[TB] FAIL abort_final c=%0d got=%h exp=%h", a, act, e);
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_start_busy();
    start = 1'b1; w_valid = 1'b1;
    for (int a = 1; a <= 80; a++) begin
      next_cycle();
      start = (a == 5 || a == 40 || a == 74);
      #1;
      total++;
      if (act !== exp_vec(a, 64)) begin
        bad++; $display("[TB] FAIL start_busy c=%0d got=%h exp=%h", a, act, exp_vec(a, 64));
      end
    end
    start = 1'b0;
  endtask

  task automatic test_async_reset();
    start = 1'b1; w_valid = 1'b1;
    for (int a = 1; a <= 59; a++) begin
      next_cycle();
      start = 1'b0;
    end
    #1;
    total++;
    if (round !== 6'd50) begin
      bad++; $display("[TB] FAIL async_pre_round got=%0d exp=50", round);
    end
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (act !== 18'd0) begin
      bad++; $display("[TB] FAIL async_reset_immediate got=%h exp=0", act);
    end
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int a = 0; a < 6; a++) begin
      next_cycle();
      #1;
      total++;
      if (act !== 18'd0) begin
        bad++; $display("[TB] FAIL async_idle_hold i=%0d got=%h exp=0", a, act);
      end
    end
  endtask

  task automatic test_param();
    start = 1'b1; w_valid = 1'b1;
    for (int a = 1; a <= 16; a++) begin
      next_cycle();
      start = 1'b0;
      #1;
      total++;
      if (act4 !== exp_vec(a, 4)) begin
        bad++; $display("[TB] FAIL param4 c=%0d got=%h exp=%h", a, act4, exp_vec(a, 4));
      end
    end
    total++;
    if (busy !== 1'b1 || round !== 6'd7) begin
      bad++; $display("[TB] FAIL param64_parallel busy=%b round=%0d exp busy=1 round=7", busy, round);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_abort();
    test_start_busy();
    test_async_reset();
    test_param();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
